fsm_stim_driver: RTL and testbench

- Initiator-side companion of the k/m/l decision FSM.
- Accepts a target-state command and drives the FSM's a/b/c inputs through the pattern sequence that reaches that state.
- After the sequence, it checks the FSM's k/m/l outputs and returns a pass/fail response.
- Used as the on-chip sequencer/self-test front end for the FSM.

---
 rtl/fsm_stim_driver.sv | 202 ++++++++++++++++++++
 tb/tb_fsm_stim_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stim_driver.sv
// fsm_stim_driver
//   Initiator-side sequencer for the k/m/l decision FSM. It accepts a target
//   state command and drives the FSM's a/b/c inputs through the step pattern
//   that reaches that state. It holds for SETTLE_CYCLES cycles, then samples
//   {k,m,l} and returns a pass/fail response.
//
//   Optional feature: define FSM_STIM_ERRCNT_EN to add err_count. This is a
//   saturating count of accepted responses that have resp_ok=0.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_target 0=IDLE 1=K 2=ML 3=M 4=L
//   resp_valid/ready     response handshake; resp_ok, resp_klm (sampled k,m,l)
//   a, b, c              registered drive to the FSM inputs
//   k, m, l              FSM outputs
//   err_count            (FSM_STIM_ERRCNT_EN only) failed-response count
module fsm_stim_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_target,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_ok,
  output logic [2:0] resp_klm,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       k,
  input  logic       m,
  input  logic       l
`ifdef FSM_STIM_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_STEP1, S_STEP2, S_SETTLE, S_RESP
  } state_t;

  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T_K    = 3'd1;
  localparam logic [2:0] T_ML   = 3'd2;
  localparam logic [2:0] T_M    = 3'd3;
  localparam logic [2:0] T_L    = 3'd4;

  localparam logic [2:0] P_CLR  = 3'b000;
  localparam logic [2:0] P_HOLD = 3'b001;  // no FSM transition from any state

  // The counter is loaded on entry to S_SETTLE and leaves at zero.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] target_q, target_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_ok_q, resp_ok_d;
  logic [2:0] resp_klm_q, resp_klm_d;
  logic [2:0] exp_klm;
`ifdef FSM_STIM_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
`endif

  always_comb begin
    exp_klm = 3'b000;
    case (target_q)
      T_K:     exp_klm = 3'b100;
      T_M:     exp_klm = 3'b010;
      T_L:     exp_klm = 3'b001;
      default: exp_klm = 3'b000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    abc_d        = abc_q;
    settle_cnt_d = settle_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_ok_d    = resp_ok_q;
    resp_klm_d   = resp_klm_q;
`ifdef FSM_STIM_ERRCNT_EN
    err_count_d  = err_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        abc_d = P_HOLD;
        // cmd_ready is high throughout S_IDLE while out of reset.
        if (cmd_valid) begin
          target_d = cmd_target;
          if (cmd_target > T_L) begin
            // Illegal target: answer immediately and leave the FSM untouched.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_ok_d    = 1'b0;
            resp_klm_d   = 3'b000;
          end else begin
            state_d = S_CLR;
            abc_d   = P_CLR;
          end
        end
      end

      S_CLR: begin
        if (target_q == T_IDLE) begin
          state_d      = S_SETTLE;
          abc_d        = P_HOLD;
          settle_cnt_d = SETTLE_LAST;
        end else begin
          state_d = S_STEP1;
          abc_d   = (target_q == T_K) ? 3'b010 : 3'b110;
        end
      end

      S_STEP1: begin
        if (target_q == T_K || target_q == T_ML) begin
          state_d      = S_SETTLE;
          abc_d        = P_HOLD;
          settle_cnt_d = SETTLE_LAST;
        end else begin
          state_d = S_STEP2;
          abc_d   = (target_q == T_M) ? 3'b011 : 3'b111;
        end
      end

      S_STEP2: begin
        state_d      = S_SETTLE;
        abc_d        = P_HOLD;
        settle_cnt_d = SETTLE_LAST;
      end

      S_SETTLE: begin
        abc_d = P_HOLD;
        if (settle_cnt_q == 8'd0) begin
          // Sample on the edge that ends the last hold cycle.
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_klm_d   = {k, m, l};
          resp_ok_d    = ({k, m, l} == exp_klm);
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        abc_d = P_HOLD;
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
`ifdef FSM_STIM_ERRCNT_EN
          if (!resp_ok_q && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= 3'd0;
      abc_q        <= P_CLR;  // forces the FSM to IDLE while in reset
      settle_cnt_q <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_klm_q   <= 3'b000;
`ifdef FSM_STIM_ERRCNT_EN
      err_count_q  <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      abc_q        <= abc_d;
      settle_cnt_q <= settle_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_klm_q   <= resp_klm_d;
`ifdef FSM_STIM_ERRCNT_EN
      err_count_q  <= err_count_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_IDLE) && rst_n;
  assign resp_valid = resp_valid_q;
  assign resp_ok    = resp_ok_q;
  assign resp_klm   = resp_klm_q;
  assign {a, b, c}  = abc_q;
`ifdef FSM_STIM_ERRCNT_EN
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_fsm_stim_driver.sv
// tb_fsm_stim_driver
//   Testbench for fsm_stim_driver. Instance 0 uses SETTLE_CYCLES=1 and
//   instance 1 uses SETTLE_CYCLES=4. Each instance drives a small
//   behavioural model of the k/m/l FSM. Expected responses go into a
//   scoreboard queue when a command is accepted. A per-instance monitor pops
//   an entry on each rising resp_valid and checks ok, klm and arrival cycle.
module tb_fsm_stim_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] cmd_valid;
  logic [2:0] cmd_target [2];
  logic [1:0] resp_ready;
  logic [1:0] k_force;
  wire  [1:0] cmd_ready, resp_valid, resp_ok;
  wire  [2:0] resp_klm [2];
  wire  [1:0] a, b, c, k, m, l;
`ifdef FSM_STIM_ERRCNT_EN
  wire  [7:0] err_count [2];
`endif

  typedef struct {
    int         idx;
    logic       ok;
    logic [2:0] klm;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [2:0] klm_of(input int st);
    case (st)
      1:       return 3'b100;
      3:       return 3'b010;
      4:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    fsm_stim_driver #(.SETTLE_CYCLES(gi == 0 ? 1 : 4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid[gi]),
      .cmd_ready  (cmd_ready[gi]),
      .cmd_target (cmd_target[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_ready (resp_ready[gi]),
      .resp_ok    (resp_ok[gi]),
      .resp_klm   (resp_klm[gi]),
      .a          (a[gi]),
      .b          (b[gi]),
      .c          (c[gi]),
      .k          (k[gi]),
      .m          (m[gi]),
      .l          (l[gi])
`ifdef FSM_STIM_ERRCNT_EN
      ,
      .err_count  (err_count[gi])
`endif
    );

    // Model of the k/m/l FSM: 0=IDLE 1=K 2=ML 3=M 4=L.
    int st = 0;
    always @(posedge clk) begin
      if ({a[gi], b[gi], c[gi]} == 3'b000) st <= 0;
      else begin
        case (st)
          0: if ({a[gi], b[gi], c[gi]} == 3'b010) st <= 1;
             else if ({a[gi], b[gi], c[gi]} == 3'b110) st <= 2;
          2: if ({a[gi], b[gi], c[gi]} == 3'b011) st <= 3;
             else if ({a[gi], b[gi], c[gi]} == 3'b111) st <= 4;
          default: ;
        endcase
      end
    end
    wire [2:0] model_klm = klm_of(st);
    assign k[gi] = model_klm[2] | k_force[gi];
    assign m[gi] = model_klm[1];
    assign l[gi] = model_klm[0];

    // Response monitor.
    logic rv_prev = 1'b0;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) rv_prev = 1'b0;
      else begin
        if (resp_valid[gi] && !rv_prev) begin
          chk("resp_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("resp_inst", gi, e.idx);
            chk("resp_ok", 32'(resp_ok[gi]), 32'(e.ok));
            chk("resp_klm", 32'(resp_klm[gi]), 32'(e.klm));
            chk("resp_cycle", cyc, e.cyc);
            $display("resp inst=%0d ok=%0b klm=%03b cyc=%0d", gi, resp_ok[gi], resp_klm[gi], cyc);
          end
        end
        rv_prev = resp_valid[gi];
      end
    end
  end

  // Waits for cmd_ready, then issues one command. lat is the cycle (counting
  // the first drive cycle as 1) in which resp_valid is expected to rise.
  // The task returns #1 into cycle 1.
  task automatic issue(input int idx, input logic [2:0] tgt, input bit push,
                       input logic ok, input logic [2:0] klm, input int lat);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready[idx]), 32'd1);
    cmd_valid[idx]  = 1'b1;
    cmd_target[idx] = tgt;
    @(posedge clk);
    #1;
    cmd_valid[idx] = 1'b0;
    if (push) sb_q.push_back('{idx, ok, klm, cyc + lat - 1});
    $display("cmd inst=%0d target=%0d cyc=%0d", idx, tgt, cyc);
  endtask

  task automatic chk_abc(input int idx, input string nm, input logic [2:0] exp);
    @(negedge clk);
    chk(nm, 32'({a[idx], b[idx], c[idx]}), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cmd_valid = 2'b00;
    cmd_target[0] = 3'd0;
    cmd_target[1] = 3'd0;
    resp_ready = 2'b11;
    k_force = 2'b00;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_abc0", 32'({a[0], b[0], c[0]}), 32'd0);
    chk("rst_abc1", 32'({a[1], b[1], c[1]}), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_resp_ok", 32'(resp_ok[0]), 32'd0);
    chk("rst_resp_klm", 32'(resp_klm[0]), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rel_abc", 32'({a[0], b[0], c[0]}), 32'd0);
    chk_abc(0, "idle_hold", 3'b001);

    // L with SETTLE_CYCLES=1.
    issue(0, 3'd4, 1'b1, 1'b1, 3'b001, 5);
    chk_abc(0, "L_c1", 3'b000);
    chk_abc(0, "L_c2", 3'b110);
    chk_abc(0, "L_c3", 3'b111);
    chk_abc(0, "L_c4", 3'b001);

    // K, then M back-to-back.
    issue(0, 3'd1, 1'b1, 1'b1, 3'b100, 4);
    issue(0, 3'd3, 1'b1, 1'b1, 3'b010, 5);
    chk_abc(0, "M_c1", 3'b000);
    chk_abc(0, "M_c2", 3'b110);
    chk_abc(0, "M_c3", 3'b011);

    // ML with k forced high in the sample cycle.
`ifdef FSM_STIM_ERRCNT_EN
    @(negedge clk);
    chk("err_count_0", 32'(err_count[0]), 32'd0);
`endif
    issue(0, 3'd2, 1'b1, 1'b0, 3'b100, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    k_force[0] = 1'b1;
    @(posedge clk); #1;
    k_force[0] = 1'b0;
    repeat (2) @(negedge clk);
`ifdef FSM_STIM_ERRCNT_EN
    chk("err_count_1", 32'(err_count[0]), 32'd1);
`endif

    // Illegal target with resp_ready held low for 5 cycles.
    resp_ready[0] = 1'b0;
    issue(0, 3'd6, 1'b1, 1'b0, 3'b000, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ill_resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("ill_resp_ok", 32'(resp_ok[0]), 32'd0);
      chk("ill_resp_klm", 32'(resp_klm[0]), 32'd0);
      chk("ill_cmd_ready", 32'(cmd_ready[0]), 32'd0);
      chk("ill_abc", 32'({a[0], b[0], c[0]}), 32'b001);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("ill_released", 32'(resp_valid[0]), 32'd0);
    chk("ill_cmd_ready_back", 32'(cmd_ready[0]), 32'd1);
`ifdef FSM_STIM_ERRCNT_EN
    chk("err_count_2", 32'(err_count[0]), 32'd2);
`endif

    // IDLE target with SETTLE_CYCLES=4.
    issue(1, 3'd0, 1'b1, 1'b1, 3'b000, 6);
    chk_abc(1, "I4_c1", 3'b000);
    for (int i = 0; i < 4; i++) chk_abc(1, "I4_settle", 3'b001);

    // Reset during STEP2 of L.
    issue(0, 3'd4, 1'b0, 1'b0, 3'b000, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_step2_abc", 32'({a[0], b[0], c[0]}), 32'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_abc", 32'({a[0], b[0], c[0]}), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid[0]), 32'd0);
    end
    issue(0, 3'd1, 1'b1, 1'b1, 3'b100, 4);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
